// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader and its matching decoder:
// instruction field positions, the STORE opcode, condition codes, FSM states,
// and the single encoding function both sides agree on.
package instr_encoder_loader_pkg;

    localparam int INSTR_W = 16;

    localparam int COND_MSB = 15;
    localparam int COND_LSB = 14;
    localparam int OP_MSB   = 13;
    localparam int OP_LSB   = 10;
    localparam int DEST_MSB = 9;
    localparam int DEST_LSB = 7;
    localparam int SRC1_MSB = 6;
    localparam int SRC1_LSB = 4;
    localparam int SRC2_MSB = 3;
    localparam int SRC2_LSB = 1;
    localparam int IMM7_MSB = 6;
    localparam int IMM7_LSB = 0;

    localparam logic [3:0] OP_STORE = 4'b1110;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_ZERO   = 2'b01,
        COND_GE     = 2'b10,
        COND_LT     = 2'b11
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // STORE has no destination, so the dest slot carries the register being
    // stored (src2); the immediate format reuses the src1/src2/bit0 area.
    function automatic logic [INSTR_W-1:0] encode_instr(
        input logic [1:0] cond,
        input logic [3:0] opcode,
        input logic [2:0] dest,
        input logic [2:0] src1,
        input logic [2:0] src2,
        input logic       imm,
        input logic [6:0] imm7
    );
        logic [INSTR_W-1:0] word;
        logic [2:0]         dest_field;
        dest_field = (opcode == OP_STORE) ? src2 : dest;
        word = '0;
        word[COND_MSB:COND_LSB] = cond;
        word[OP_MSB:OP_LSB]     = opcode;
        word[DEST_MSB:DEST_LSB] = dest_field;
        if (imm) begin
            word[IMM7_MSB:IMM7_LSB] = imm7;
        end else begin
            word[SRC1_MSB:SRC1_LSB] = src1;
            word[SRC2_MSB:SRC2_LSB] = src2;
            word[0]                 = 1'b0;
        end
        return word;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake from the instruction producer plus the instruction
// memory write port. The loader is the slave; the producer/memory side is master.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    import instr_encoder_loader_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_cond;
    logic [3:0]          in_opcode;
    logic [2:0]          in_dest;
    logic [2:0]          in_src1;
    logic [2:0]          in_src2;
    logic                in_imm;
    logic [6:0]          in_imm7;

    logic                imem_we;
    logic [ADDR_W-1:0]   imem_addr;
    logic [INSTR_W-1:0]  imem_wdata;

    modport master (
        output in_valid, in_cond, in_opcode, in_dest, in_src1, in_src2, in_imm, in_imm7,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_cond, in_opcode, in_dest, in_src1, in_src2, in_imm, in_imm7,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/instr_encoder_loader_fifo.sv
// Small synchronous FIFO with registered storage. Pointers carry one extra
// wrap bit so full and empty can be told apart without a separate counter.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_idx;
    logic [AW:0]      rd_idx;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Advance read/write pointers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx <= '0;
            rd_idx <= '0;
        end else begin
            if (do_push) wr_idx <= wr_idx + 1'b1;
            if (do_pop)  rd_idx <= rd_idx + 1'b1;
        end
    end

    // Storage needs no reset: the empty flag guards every read of stale data.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx[AW-1:0]] <= wdata;
    end

    // Head word and occupancy flags derived from the pointers.
    always_comb begin
        rdata = mem[rd_idx[AW-1:0]];
        count = wr_idx - rd_idx;
        empty = (wr_idx == rd_idx);
        full  = (wr_idx[AW] != rd_idx[AW]) && (wr_idx[AW-1:0] == rd_idx[AW-1:0]);
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: encodes field bundles into 16-bit instructions,
// buffers them, and writes them to consecutive instruction-memory addresses
// for one load session started by a start pulse.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     length,
    output logic                  busy,
    output logic                  done,
    instr_encoder_loader_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e              state;
    state_e              state_next;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   remaining;
    logic [INSTR_W-1:0]  enc_word;
    logic [INSTR_W-1:0]  fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                ready;
    logic                accept;
    logic                pop;
    logic                start_ok;

    // Encode the incoming bundle and derive the handshake/pop strobes.
    always_comb begin
        enc_word = encode_instr(bus.in_cond, bus.in_opcode, bus.in_dest,
                                bus.in_src1, bus.in_src2, bus.in_imm, bus.in_imm7);
        ready    = (state == ST_LOAD) && !fifo_full && (remaining != '0);
        accept   = bus.in_valid && ready;
        pop      = ((state == ST_LOAD) || (state == ST_DRAIN)) && !fifo_empty;
        start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
    end

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .wdata (enc_word),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State register plus session address pointer and remaining-bundle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            remaining <= '0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                wr_ptr    <= base_addr;
                remaining <= length;
            end else begin
                if (pop)    wr_ptr    <= wr_ptr + 1'b1;
                if (accept) remaining <= remaining - 1'b1;
            end
        end
    end

    // Next-state logic; DRAIN never sees a push, so count==1 means last word.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_next = (length != '0) ? ST_LOAD : ST_DONE;
            end
            ST_LOAD: begin
                if (accept && (remaining == ADDR_W'(1))) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pop && (fifo_count == CNT_W'(1))) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Drive the memory port and status flags; write data is zero when idle.
    always_comb begin
        bus.in_ready   = ready;
        bus.imem_we    = pop;
        bus.imem_addr  = wr_ptr;
        bus.imem_wdata = pop ? fifo_head : '0;
        busy           = (state == ST_LOAD) || (state == ST_DRAIN);
        done           = (state == ST_DONE);
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: the driver queues the expected
// address/word of every accepted bundle, and a monitor pops and compares on
// every imem write strobe.
module tb_instr_encoder_loader;
    import instr_encoder_loader_pkg::*;

    localparam int ADDR_W     = 8;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        logic [1:0]  cond;
        logic [3:0]  opcode;
        logic [2:0]  dest;
        logic [2:0]  src1;
        logic [2:0]  src2;
        logic        imm;
        logic [6:0]  imm7;
        logic [15:0] word;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic              busy;
    logic              done;

    instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder_loader #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bus       (bus.slave)
    );

    vec_t vecs [7];
    exp_t exp_q [$];
    int   vectors_applied  = 0;
    int   miscompares      = 0;
    int   neg_cycle        = 0;
    int   last_write_cycle = -10;
    int   session_writes   = 0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        neg_cycle++;
        if (bus.imem_we === 1'b1) begin
            session_writes++;
            last_write_cycle = neg_cycle;
            if (exp_q.size() == 0) begin
                vectors_applied++;
                miscompares++;
                $display("[TB] FAIL unexpected_write: got write addr 0x%0h data 0x%0h, expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                e = exp_q.pop_front();
                checkOutput("imem_addr", 32'(bus.imem_addr), 32'(e.addr));
                checkOutput("imem_wdata", 32'(bus.imem_wdata), 32'(e.data));
            end
        end
    end

    task automatic sampleTick();
        @(negedge clk);
        #1;
    endtask

    task automatic driveVec(input int idx);
        bus.in_cond   = vecs[idx].cond;
        bus.in_opcode = vecs[idx].opcode;
        bus.in_dest   = vecs[idx].dest;
        bus.in_src1   = vecs[idx].src1;
        bus.in_src2   = vecs[idx].src2;
        bus.in_imm    = vecs[idx].imm;
        bus.in_imm7   = vecs[idx].imm7;
    endtask

    // Start a session and hold in_valid high, queuing each accepted bundle.
    // abort_after>0 asserts rst once that many writes have been seen;
    // poke_start pulses a stray start in the middle of the load.
    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len,
                                 input int first, input int abort_after, input bit poke_start);
        int                accepted;
        int                ready_low;
        int                guard;
        logic [ADDR_W-1:0] addr;
        logic              rdy;
        bit                aborted;
        exp_t              e;
        accepted  = 0;
        ready_low = 0;
        guard     = 0;
        addr      = base;
        aborted   = 1'b0;
        session_writes = 0;
        @(posedge clk);
        #1;
        base_addr    = base;
        length       = len;
        start        = 1'b1;
        driveVec(first % 7);
        bus.in_valid = (len != '0);
        @(posedge clk);
        #1;
        start = 1'b0;
        while (accepted < int'(len) && guard < 100) begin
            @(negedge clk);
            #1;
            rdy = bus.in_ready;
            if (rdy !== 1'b1) ready_low++;
            if (guard == 0) checkOutput("busy_in_load", 32'(busy), 32'd1);
            if (abort_after > 0 && session_writes >= abort_after) begin
                aborted = 1'b1;
                rst     = 1'b1;
                break;
            end
            @(posedge clk);
            if (rdy === 1'b1) begin
                e.addr = addr;
                e.data = vecs[(first + accepted) % 7].word;
                exp_q.push_back(e);
                addr++;
                accepted++;
            end
            #1;
            start = poke_start && (accepted == 3);
            if (start) begin
                base_addr = 8'h80;
                length    = 8'h01;
            end
            driveVec((first + accepted) % 7);
            guard++;
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
        if (aborted) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            exp_q.delete();
        end else if (len != '0) begin
            if (guard >= 100) checkOutput("accept_timeout", 32'(accepted), 32'(len));
            checkOutput("ready_stall_cycles", 32'(ready_low), 32'd0);
            sampleTick();
            checkOutput("ready_after_last", 32'(bus.in_ready), 32'd0);
        end
    endtask

    task automatic waitDone(input int exp_writes);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            sampleTick();
            n++;
        end
        if (done !== 1'b1) checkOutput("done_timeout", 32'(done), 32'd1);
        else checkOutput("done_latency", 32'(neg_cycle - last_write_cycle), 32'd1);
        checkOutput("write_count", 32'(session_writes), 32'(exp_writes));
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("busy_when_done", 32'(busy), 32'd0);
        checkOutput("we_when_done", 32'(bus.imem_we), 32'd0);
    endtask

    // Hard stop if something wedges the sequence below.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sessions.
    initial begin
        vecs[0] = '{2'b01, 4'b0011, 3'd5, 3'd2, 3'd7, 1'b0, 7'h00, 16'h4EAE};
        vecs[1] = '{2'b00, 4'b1110, 3'd1, 3'd3, 3'd4, 1'b0, 7'h00, 16'h3A38};
        vecs[2] = '{2'b10, 4'b0001, 3'd6, 3'd0, 3'd0, 1'b1, 7'h55, 16'h8755};
        vecs[3] = '{2'b11, 4'b1110, 3'd7, 3'd0, 3'd2, 1'b1, 7'h7F, 16'hF97F};
        vecs[4] = '{2'b11, 4'b1111, 3'd0, 3'd7, 3'd0, 1'b0, 7'h7F, 16'hFC70};
        vecs[5] = '{2'b00, 4'b0000, 3'd2, 3'd5, 3'd1, 1'b1, 7'h00, 16'h0100};
        vecs[6] = '{2'b10, 4'b1000, 3'd3, 3'd4, 3'd6, 1'b0, 7'h00, 16'hA1CC};

        rst          = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        length       = '0;
        bus.in_valid = 1'b0;
        driveVec(0);
        repeat (2) @(posedge clk);
        sampleTick();
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_imem_we", 32'(bus.imem_we), 32'd0);
        checkOutput("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        checkOutput("rst_imem_wdata", 32'(bus.imem_wdata), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] session: base 0xFE, length 4, address wrap");
        applyStimulus(8'hFE, 8'd4, 0, 0, 1'b0);
        waitDone(4);

        $display("[TB] session: base 0x10, length 6, stray start mid-load");
        applyStimulus(8'h10, 8'd6, 1, 0, 1'b1);
        waitDone(6);

        $display("[TB] session: base 0x20, length 4, reset after two writes");
        applyStimulus(8'h20, 8'd4, 4, 2, 1'b0);
        checkOutput("abort_write_count", 32'(session_writes), 32'd2);
        repeat (2) begin
            sampleTick();
            checkOutput("post_rst_imem_we", 32'(bus.imem_we), 32'd0);
            checkOutput("post_rst_done", 32'(done), 32'd0);
            checkOutput("post_rst_busy", 32'(busy), 32'd0);
            checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd0);
        end

        $display("[TB] session: length 0");
        applyStimulus(8'h40, 8'd0, 0, 0, 1'b0);
        sampleTick();
        checkOutput("len0_done", 32'(done), 32'd1);
        checkOutput("len0_busy", 32'(busy), 32'd0);
        sampleTick();
        checkOutput("len0_done_held", 32'(done), 32'd1);
        checkOutput("len0_writes", 32'(session_writes), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
